// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: op codes, FSM states,
// op classification helpers.
package dmem_pkg;

  localparam int unsigned OP_W = 5;

  localparam logic [OP_W-1:0] OP_LB  = 5'b01010;
  localparam logic [OP_W-1:0] OP_LH  = 5'b01011;
  localparam logic [OP_W-1:0] OP_LW  = 5'b01100;
  localparam logic [OP_W-1:0] OP_LBU = 5'b01101;
  localparam logic [OP_W-1:0] OP_LHU = 5'b01110;
  localparam logic [OP_W-1:0] OP_SB  = 5'b01111;
  localparam logic [OP_W-1:0] OP_SH  = 5'b10000;
  localparam logic [OP_W-1:0] OP_SW  = 5'b10001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic is_load(input logic [OP_W-1:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_store(input logic [OP_W-1:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_half(input logic [OP_W-1:0] op);
    return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
  endfunction

  function automatic logic is_word(input logic [OP_W-1:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between the core's load/store unit
// (master) and the data-memory responder (slave).
interface dmem_responder_if
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [OP_W-1:0]   req_op;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_op, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lane_ext.sv
// Load data alignment: picks the byte/half lane out of a RAM word and
// sign- or zero-extends it to 32 bits. Non-load ops yield zero.
module dmem_lane_ext
  import dmem_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic [1:0]      lane,
  input  logic [31:0]     word,
  output logic [31:0]     rdata
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by extension according to the load op
  always_comb begin
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? word[31:16] : word[15:0];
    rdata    = '0;
    case (op)
      OP_LB:   rdata = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  rdata = {24'h000000, byte_sel};
      OP_LH:   rdata = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  rdata = {16'h0000, half_sel};
      OP_LW:   rdata = word;
      default: rdata = '0;
    endcase
  end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store per handshake, commits it to
// an inferred byte-writable word RAM after LATENCY cycles and holds the
// response until consumed.
// Optional build macro: DMEM_MISALIGN_TRAP_EN (flag misaligned half/word
// accesses as errors instead of forcing the address aligned).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned LATENCY = 1
)(
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q;
  logic [OP_W-1:0]   op_q;
  logic              we_q;
  logic [IDX_W-1:0]  idx_q;
  logic [1:0]        lane_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic [31:0]       mem [DEPTH];

  logic              accept;
  logic              commit;
  logic              misalign;
  logic              bad;
  logic              wr_en;
  logic [1:0]        lane_eff;
  logic [3:0]        be;
  logic [31:0]       wlane;
  logic [31:0]       rd_word;
  logic [31:0]       ext;

  assign accept        = bus.req_valid && (state_q == ST_IDLE);
  assign commit        = (state_q == ST_BUSY) && (cnt_q == 4'd0);
  assign rd_word       = mem[idx_q];
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  // Alignment handling, error classification and store byte-lane steering
  always_comb begin
`ifdef DMEM_MISALIGN_TRAP_EN
    misalign = (is_half(op_q) && lane_q[0]) || (is_word(op_q) && (lane_q != 2'b00));
    lane_eff = lane_q;
`else
    misalign = 1'b0;
    if (is_word(op_q))      lane_eff = 2'b00;
    else if (is_half(op_q)) lane_eff = {lane_q[1], 1'b0};
    else                    lane_eff = lane_q;
`endif
    bad = !((is_load(op_q) && !we_q) || (is_store(op_q) && we_q)) || misalign;
    be    = 4'b0000;
    wlane = wdata_q;
    case (op_q)
      OP_SB: begin
        be    = 4'b0001 << lane_eff;
        wlane = {4{wdata_q[7:0]}};
      end
      OP_SH: begin
        be    = lane_eff[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata_q[15:0]}};
      end
      OP_SW:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    // A write whose commit edge coincides with reset is dropped
    wr_en = commit && !bad && !rst;
  end

  dmem_lane_ext u_lane_ext (
    .op    (op_q),
    .lane  (lane_eff),
    .word  (rd_word),
    .rdata (ext)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
      end
      ST_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request capture, latency countdown and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      op_q    <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      lane_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      cnt_q   <= 4'(LATENCY - 1);
      op_q    <= bus.req_op;
      we_q    <= bus.req_we;
      idx_q   <= IDX_W'((bus.req_addr >> 2) % ADDR_W'(DEPTH));
      lane_q  <= bus.req_addr[1:0];
      wdata_q <= bus.req_wdata;
    end else if (state_q == ST_BUSY) begin
      if (cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end else begin
        rdata_q <= (bad || !is_load(op_q)) ? '0 : ext;
        err_q   <= bad;
      end
    end
  end

  // Byte-enabled RAM write at commit; contents are never reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[idx_q][i*8 +: 8] <= wlane[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (LATENCY overridden to 3).
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int unsigned LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  dmem_responder_if #(.ADDR_W(32)) bus ();

  dmem_responder #(
    .DEPTH   (1024),
    .ADDR_W  (32),
    .LATENCY (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Wait for IDLE, present one request, return cycles from accept edge to rsp_valid
  task automatic issue(input logic [4:0] op, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, output int lat);
    int guard;
    lat = -1;
    @(negedge clk);
    guard = 0;
    while (!bus.req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.req_ready) begin
      check("idle_timeout", {31'b0, bus.req_ready}, 32'd1);
      return;
    end
    bus.req_op    = op;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.rsp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.rsp_valid) check("rsp_timeout", {31'b0, bus.rsp_valid}, 32'd1);
  endtask

  task automatic take();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    check("valid_after_take", {31'b0, bus.rsp_valid}, 32'd0);
  endtask

  task automatic xfer(input string tag, input logic [4:0] op, input logic we,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rdata, input logic exp_err);
    int lat;
    issue(op, we, addr, wd, lat);
    check({tag, "_lat"}, lat, LAT);
    check({tag, "_rdata"}, bus.rsp_rdata, exp_rdata);
    check({tag, "_err"}, {31'b0, bus.rsp_err}, {31'b0, exp_err});
    take();
  endtask

  initial begin
    int lat;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("rst_rdata", bus.rsp_rdata, 32'd0);
    check("rst_err", {31'b0, bus.rsp_err}, 32'd0);
    rst = 1'b0;

    // Word store/load and latency
    xfer("sw10", OP_SW, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    xfer("lw10", OP_LW, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // Sub-word loads with extension
    xfer("lb13",  OP_LB,  1'b0, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
    xfer("lbu13", OP_LBU, 1'b0, 32'h13, 32'h0, 32'h000000DE, 1'b0);
    xfer("lh12",  OP_LH,  1'b0, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0);
    xfer("lhu10", OP_LHU, 1'b0, 32'h10, 32'h0, 32'h0000BEEF, 1'b0);
    xfer("lbu11", OP_LBU, 1'b0, 32'h11, 32'h0, 32'h000000BE, 1'b0);
    xfer("lb10",  OP_LB,  1'b0, 32'h10, 32'h0, 32'hFFFFFFEF, 1'b0);

    // Sub-word stores with byte enables
    xfer("sb11",   OP_SB, 1'b1, 32'h11, 32'h00000055, 32'h0, 1'b0);
    xfer("lw_sb",  OP_LW, 1'b0, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0);
    xfer("sh12",   OP_SH, 1'b1, 32'h12, 32'h00001234, 32'h0, 1'b0);
    xfer("lw_sh",  OP_LW, 1'b0, 32'h10, 32'h0, 32'h123455EF, 1'b0);

    // Error cases leave memory untouched
    xfer("badop",   5'b00000, 1'b1, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1);
    xfer("lw_we1",  OP_LW,    1'b1, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1);
    xfer("sw_we0",  OP_SW,    1'b0, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1);
    xfer("lw_keep", OP_LW,    1'b0, 32'h10, 32'h0, 32'h123455EF, 1'b0);

    // Misaligned word load
`ifdef DMEM_MISALIGN_TRAP_EN
    xfer("lw11", OP_LW, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1);
`else
    xfer("lw11", OP_LW, 1'b0, 32'h11, 32'h0, 32'h123455EF, 1'b0);
`endif

    // Address wrap: 0x1010 maps to the same word as 0x10
    xfer("sw_wrap", OP_SW, 1'b1, 32'h1010, 32'hCAFEF00D, 32'h0, 1'b0);
    xfer("lw_wrap", OP_LW, 1'b0, 32'h10, 32'h0, 32'hCAFEF00D, 1'b0);

    // Baseline for the reset-abort test
    xfer("sw20", OP_SW, 1'b1, 32'h20, 32'h11111111, 32'h0, 1'b0);

    // Backpressure: response held while rsp_ready stays low
    issue(OP_LW, 1'b0, 32'h10, 32'h0, lat);
    check("hold_lat", lat, LAT);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", {31'b0, bus.rsp_valid}, 32'd1);
      check("hold_rdata", bus.rsp_rdata, 32'hCAFEF00D);
      check("hold_req_ready", {31'b0, bus.req_ready}, 32'd0);
    end
    take();

    // Reset on the commit edge of an in-flight store
    @(negedge clk);
    check("pre_abort_ready", {31'b0, bus.req_ready}, 32'd1);
    bus.req_op    = OP_SW;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h20;
    bus.req_wdata = 32'h22222222;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (LAT - 1) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("abort_req_ready", {31'b0, bus.req_ready}, 32'd1);
    check("abort_rdata", bus.rsp_rdata, 32'd0);
    check("abort_err", {31'b0, bus.rsp_err}, 32'd0);
    rst = 1'b0;
    xfer("lw20", OP_LW, 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
